// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Brief    : Two-port bounded round-robin arbiter in front of d_mem, with
//            tagged routing of read data back to the owning requester.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 4
) (
  input  logic              clk,
  input  logic              rst,
  // port A (core)
  input  logic              a_req,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  input  logic [1:0]        a_mask,
  input  logic              a_we,
  input  logic              a_re,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  // port B (loader / debug / DMA)
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  input  logic [1:0]        b_mask,
  input  logic              b_we,
  input  logic              b_re,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  // d_mem side
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_write_data,
  output logic [1:0]        mem_data_mask,
  output logic              mem_write_en,
  output logic              mem_read_en,
  input  logic [DATA_W-1:0] mem_read_data
);

  localparam int               c_cnt_w     = $clog2(MAX_BURST + 1);
  localparam logic [c_cnt_w-1:0] c_max_burst = c_cnt_w'(MAX_BURST);
  localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
  localparam logic             c_port_a    = 1'b0;
  localparam logic             c_port_b    = 1'b1;

  logic               r_last_owner;
  logic [c_cnt_w-1:0] r_run_cnt;
  logic               r_tag_valid [READ_LATENCY];
  logic               r_tag_owner [READ_LATENCY];

  logic w_contend;
  logic w_under_cap;
  logic w_pick_b;
  logic w_any_gnt;
  logic w_a_gnt;
  logic w_b_gnt;
  logic w_sel_we;
  logic w_sel_re;
  logic w_tag_out;

  // ---------------------------------------------------------------- grant
  assign w_contend   = a_req & b_req;
  assign w_under_cap = (r_run_cnt < c_max_burst);
  // Under contention the incumbent keeps the port until its burst is spent.
  assign w_pick_b    = w_contend ? (w_under_cap ? r_last_owner : ~r_last_owner) : b_req;
  assign w_any_gnt   = (a_req | b_req) & ~rst;
  assign w_a_gnt     = w_any_gnt & ~w_pick_b;
  assign w_b_gnt     = w_any_gnt &  w_pick_b;

  assign a_gnt = w_a_gnt;
  assign b_gnt = w_b_gnt;

  // ------------------------------------------------------------ memory mux
  assign w_sel_we       = w_b_gnt ? b_we    : a_we;
  assign w_sel_re       = w_b_gnt ? b_re    : a_re;
  assign mem_addr       = w_b_gnt ? b_addr  : a_addr;
  assign mem_write_data = w_b_gnt ? b_wdata : a_wdata;
  assign mem_data_mask  = w_b_gnt ? b_mask  : a_mask;
  assign mem_write_en   = w_any_gnt & w_sel_we;
  assign mem_read_en    = w_any_gnt & w_sel_re & ~w_sel_we;

  // --------------------------------------------------------- burst tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_owner <= c_port_a;
      r_run_cnt    <= '0;
    end else if (w_any_gnt) begin
      if (w_pick_b == r_last_owner) begin
        if (w_under_cap) begin
          r_run_cnt <= r_run_cnt + c_cnt_one;
        end
      end else begin
        r_last_owner <= w_pick_b;
        r_run_cnt    <= c_cnt_one;
      end
    end else begin
      r_run_cnt <= '0;
    end
  end

  // --------------------------------------------------- read-return tagging
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_tag_valid[i] <= 1'b0;
        r_tag_owner[i] <= c_port_a;
      end
    end else begin
      r_tag_valid[0] <= mem_read_en;
      r_tag_owner[0] <= w_b_gnt;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_tag_valid[i] <= r_tag_valid[i-1];
        r_tag_owner[i] <= r_tag_owner[i-1];
      end
    end
  end

  // Gated by rst so a tag emerging in the reset cycle itself is suppressed.
  assign w_tag_out = r_tag_valid[READ_LATENCY-1] & ~rst;
  assign a_rvalid  = w_tag_out & (r_tag_owner[READ_LATENCY-1] == c_port_a);
  assign b_rvalid  = w_tag_out & (r_tag_owner[READ_LATENCY-1] == c_port_b);
  assign a_rdata   = a_rvalid ? mem_read_data : '0;
  assign b_rdata   = b_rvalid ? mem_read_data : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// Bench for dmem_arbiter: two configurations (latency 1 / burst 4 and
// latency 2 / burst 1) share stimulus and are checked against a transaction model.
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          a_req, a_we, a_re, b_req, b_we, b_re;
  logic [AW-1:0] a_addr, b_addr;
  logic [DW-1:0] a_wdata, b_wdata, mem_read_data;
  logic [1:0]    a_mask, b_mask;

  logic          a_gnt [2], b_gnt [2], a_rvalid [2], b_rvalid [2];
  logic          mem_write_en [2], mem_read_en [2];
  logic [DW-1:0] a_rdata [2], b_rdata [2], mem_write_data [2];
  logic [AW-1:0] mem_addr [2];
  logic [1:0]    mem_data_mask [2];

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(1), .MAX_BURST(4)) u_dut0 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask), .a_we(a_we), .a_re(a_re),
    .a_gnt(a_gnt[0]), .a_rvalid(a_rvalid[0]), .a_rdata(a_rdata[0]),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask), .b_we(b_we), .b_re(b_re),
    .b_gnt(b_gnt[0]), .b_rvalid(b_rvalid[0]), .b_rdata(b_rdata[0]),
    .mem_addr(mem_addr[0]), .mem_write_data(mem_write_data[0]), .mem_data_mask(mem_data_mask[0]),
    .mem_write_en(mem_write_en[0]), .mem_read_en(mem_read_en[0]), .mem_read_data(mem_read_data)
  );

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .READ_LATENCY(2), .MAX_BURST(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .a_req(a_req), .a_addr(a_addr), .a_wdata(a_wdata), .a_mask(a_mask), .a_we(a_we), .a_re(a_re),
    .a_gnt(a_gnt[1]), .a_rvalid(a_rvalid[1]), .a_rdata(a_rdata[1]),
    .b_req(b_req), .b_addr(b_addr), .b_wdata(b_wdata), .b_mask(b_mask), .b_we(b_we), .b_re(b_re),
    .b_gnt(b_gnt[1]), .b_rvalid(b_rvalid[1]), .b_rdata(b_rdata[1]),
    .mem_addr(mem_addr[1]), .mem_write_data(mem_write_data[1]), .mem_data_mask(mem_data_mask[1]),
    .mem_write_en(mem_write_en[1]), .mem_read_en(mem_read_en[1]), .mem_read_data(mem_read_data)
  );

  int checks = 0;
  int errors = 0;

  // ------------------------------------------------------------ reference model
  function automatic int lat(input int k);
    return (k == 0) ? 1 : 2;
  endfunction
  function automatic int burst(input int k);
    return (k == 0) ? 4 : 1;
  endfunction

  typedef struct {
    int   k;
    int   due;
    logic own_b;
  } ret_t;

  int   cyc;
  logic owner_b [2];
  int   streak  [2];
  ret_t rq [$];

  logic          e_ag [2], e_bg [2], e_we [2], e_re [2], e_arv [2], e_brv [2];
  logic [AW-1:0] e_addr [2];
  logic [DW-1:0] e_wd [2], e_ard [2], e_brd [2];
  logic [1:0]    e_mask [2];

  task automatic model_eval();
    for (int k = 0; k < 2; k++) begin
      logic pick_b, any, we_s, re_s;
      if (a_req && b_req) pick_b = (streak[k] < burst(k)) ? owner_b[k] : !owner_b[k];
      else                pick_b = b_req;
      any       = (a_req || b_req) && !rst;
      e_ag[k]   = any && !pick_b;
      e_bg[k]   = any && pick_b;
      e_addr[k] = e_bg[k] ? b_addr  : a_addr;
      e_wd[k]   = e_bg[k] ? b_wdata : a_wdata;
      e_mask[k] = e_bg[k] ? b_mask  : a_mask;
      we_s      = e_bg[k] ? b_we    : a_we;
      re_s      = e_bg[k] ? b_re    : a_re;
      e_we[k]   = any && we_s;
      e_re[k]   = any && re_s && !we_s;
      e_arv[k]  = 1'b0;
      e_brv[k]  = 1'b0;
      if (!rst) begin
        foreach (rq[i]) begin
          if (rq[i].k == k && rq[i].due == cyc) begin
            if (rq[i].own_b) e_brv[k] = 1'b1;
            else             e_arv[k] = 1'b1;
          end
        end
      end
      e_ard[k] = e_arv[k] ? mem_read_data : '0;
      e_brd[k] = e_brv[k] ? mem_read_data : '0;
    end
  endtask

  task automatic model_commit();
    ret_t keep [$];
    ret_t r;
    keep = {};
    if (!rst) begin
      foreach (rq[i]) if (rq[i].due > cyc) keep.push_back(rq[i]);
    end
    rq = keep;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        owner_b[k] = 1'b0;
        streak[k]  = 0;
      end else if (e_ag[k] || e_bg[k]) begin
        if (e_bg[k] == owner_b[k]) streak[k]++;
        else begin
          owner_b[k] = e_bg[k];
          streak[k]  = 1;
        end
        if (e_re[k]) begin
          r.k = k; r.due = cyc + lat(k); r.own_b = e_bg[k];
          rq.push_back(r);
        end
      end else begin
        streak[k] = 0;
      end
    end
    cyc++;
  endtask

  task automatic sample();
    @(negedge clk);
    model_eval();
  endtask

  task automatic advance();
    model_commit();
    @(posedge clk);
    #1;
    mem_read_data = $urandom();
  endtask

  task automatic idle_inputs();
    a_req = 0; a_we = 0; a_re = 0; b_req = 0; b_we = 0; b_re = 0;
  endtask

  // ------------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1; a_req = 1; b_req = 1; a_re = 1; b_re = 1;
    repeat (2) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({a_gnt[k], b_gnt[k], mem_write_en[k], mem_read_en[k], a_rvalid[k], b_rvalid[k]} !== 6'b0) begin
          errors++;
          $display("FAIL reset_outputs k=%0d got gnt=%b%b en=%b%b rv=%b%b exp all 0", k,
                   a_gnt[k], b_gnt[k], mem_write_en[k], mem_read_en[k], a_rvalid[k], b_rvalid[k]);
        end
      end
      advance();
    end
    rst = 0;
    sample();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (a_gnt[k] !== 1'b1 || b_gnt[k] !== 1'b0) begin
        errors++;
        $display("FAIL reset_first_tie k=%0d got a_gnt=%b b_gnt=%b exp 1 0", k, a_gnt[k], b_gnt[k]);
      end
    end
    advance();
    idle_inputs();
    repeat (3) begin sample(); advance(); end
  endtask

  task automatic test_b_read();
    b_req = 1; b_re = 1; b_we = 0; b_addr = 32'h40;
    sample();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b_gnt[k] !== 1'b1 || mem_read_en[k] !== 1'b1 || mem_addr[k] !== 32'h40) begin
        errors++;
        $display("FAIL b_read_issue k=%0d got gnt=%b ren=%b addr=%h exp 1 1 00000040",
                 k, b_gnt[k], mem_read_en[k], mem_addr[k]);
      end
    end
    advance();
    idle_inputs();
    for (int c = 1; c <= 2; c++) begin
      mem_read_data = 32'hDEADBEEF;
      sample();
      for (int k = 0; k < 2; k++) begin
        logic exp_rv;
        exp_rv = (c == lat(k));
        checks++;
        if (b_rvalid[k] !== exp_rv || b_rdata[k] !== (exp_rv ? 32'hDEADBEEF : 32'h0) ||
            a_rvalid[k] !== 1'b0 || a_rdata[k] !== 32'h0) begin
          errors++;
          $display("FAIL b_read_return k=%0d c=%0d got b_rv=%b b_rd=%h a_rv=%b a_rd=%h exp b_rv=%b",
                   k, c, b_rvalid[k], b_rdata[k], a_rvalid[k], a_rdata[k], exp_rv);
        end
      end
      advance();
    end
  endtask

  task automatic test_contention();
    logic [8:0] seq [2];
    seq[0] = 9'b011110000;   // bit i set = B granted in cycle i
    seq[1] = 9'b010101010;
    idle_inputs();
    rst = 1; sample(); advance(); rst = 0;
    a_req = 1; b_req = 1;
    for (int i = 0; i < 9; i++) begin
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (b_gnt[k] !== seq[k][i] || a_gnt[k] !== !seq[k][i]) begin
          errors++;
          $display("FAIL contention k=%0d cycle=%0d got a_gnt=%b b_gnt=%b exp b_gnt=%b",
                   k, i, a_gnt[k], b_gnt[k], seq[k][i]);
        end
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_write();
    for (int p = 0; p < 2; p++) begin
      a_req = 1; a_we = 1; a_re = (p == 1); a_addr = 32'h100; a_wdata = 32'h12345678; a_mask = 2'b10;
      b_req = 0;
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_gnt[k] !== 1'b1 || mem_write_en[k] !== 1'b1 || mem_read_en[k] !== 1'b0 ||
            mem_addr[k] !== 32'h100 || mem_write_data[k] !== 32'h12345678 || mem_data_mask[k] !== 2'b10) begin
          errors++;
          $display("FAIL write_drive k=%0d re=%0d got gnt=%b wen=%b ren=%b addr=%h data=%h mask=%b",
                   k, p, a_gnt[k], mem_write_en[k], mem_read_en[k], mem_addr[k], mem_write_data[k], mem_data_mask[k]);
        end
      end
      advance();
      idle_inputs();
      repeat (3) begin
        sample();
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (a_rvalid[k] !== 1'b0 || b_rvalid[k] !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rvalid k=%0d re=%0d got a_rv=%b b_rv=%b exp 0 0", k, p, a_rvalid[k], b_rvalid[k]);
          end
        end
        advance();
      end
    end
  endtask

  task automatic test_interleaved();
    // A reads at cycle 0, B at cycle 1; returns expected at 0+lat and 1+lat.
    for (int c = 0; c < 4; c++) begin
      idle_inputs();
      if (c == 0) begin a_req = 1; a_re = 1; a_addr = $urandom(); end
      if (c == 1) begin b_req = 1; b_re = 1; b_addr = $urandom(); end
      sample();
      for (int k = 0; k < 2; k++) begin
        logic ea, eb;
        ea = (c == lat(k));
        eb = (c == 1 + lat(k));
        checks++;
        if (a_rvalid[k] !== ea || b_rvalid[k] !== eb ||
            a_rdata[k] !== (ea ? mem_read_data : 32'h0) || b_rdata[k] !== (eb ? mem_read_data : 32'h0)) begin
          errors++;
          $display("FAIL interleaved k=%0d cycle=%0d got a_rv=%b a_rd=%h b_rv=%b b_rd=%h exp a_rv=%b b_rv=%b data=%h",
                   k, c, a_rvalid[k], a_rdata[k], b_rvalid[k], b_rdata[k], ea, eb, mem_read_data);
        end
      end
      advance();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_read();
    b_req = 1; b_re = 1; b_addr = 32'h80;
    sample();
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (b_gnt[k] !== 1'b1) begin
        errors++;
        $display("FAIL midrst_issue k=%0d got b_gnt=%b exp 1", k, b_gnt[k]);
      end
    end
    advance();
    for (int c = 1; c <= 3; c++) begin
      idle_inputs();
      rst = (c == 1);
      if (c <= 2) begin a_req = 1; b_req = 1; end
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if (a_rvalid[k] !== 1'b0 || b_rvalid[k] !== 1'b0) begin
          errors++;
          $display("FAIL midrst_no_rvalid k=%0d cycle=%0d got a_rv=%b b_rv=%b exp 0 0", k, c, a_rvalid[k], b_rvalid[k]);
        end
        if (c == 2) begin
          checks++;
          if (a_gnt[k] !== 1'b1 || b_gnt[k] !== 1'b0) begin
            errors++;
            $display("FAIL midrst_tie k=%0d got a_gnt=%b b_gnt=%b exp 1 0", k, a_gnt[k], b_gnt[k]);
          end
        end
      end
      advance();
    end
    rst = 0;
    idle_inputs();
  endtask

  task automatic test_random(input int n);
    for (int i = 0; i < n; i++) begin
      rst     = ($urandom_range(0, 59) == 0);
      a_req   = ($urandom_range(0, 3) != 0);
      b_req   = ($urandom_range(0, 3) != 0);
      a_we    = ($urandom_range(0, 3) == 0);
      b_we    = ($urandom_range(0, 3) == 0);
      a_re    = $urandom_range(0, 1);
      b_re    = $urandom_range(0, 1);
      a_addr  = $urandom();  b_addr  = $urandom();
      a_wdata = $urandom();  b_wdata = $urandom();
      a_mask  = 2'($urandom_range(0, 2));
      b_mask  = 2'($urandom_range(0, 2));
      sample();
      for (int k = 0; k < 2; k++) begin
        checks++;
        if ({a_gnt[k], b_gnt[k], mem_write_en[k], mem_read_en[k], a_rvalid[k], b_rvalid[k]} !==
            {e_ag[k], e_bg[k], e_we[k], e_re[k], e_arv[k], e_brv[k]}) begin
          errors++;
          $display("FAIL rand_ctrl k=%0d i=%0d got %b%b%b%b%b%b exp %b%b%b%b%b%b", k, i,
                   a_gnt[k], b_gnt[k], mem_write_en[k], mem_read_en[k], a_rvalid[k], b_rvalid[k],
                   e_ag[k], e_bg[k], e_we[k], e_re[k], e_arv[k], e_brv[k]);
        end
        checks++;
        if ({mem_addr[k], mem_write_data[k], mem_data_mask[k]} !== {e_addr[k], e_wd[k], e_mask[k]}) begin
          errors++;
          $display("FAIL rand_mux k=%0d i=%0d got %h %h %b exp %h %h %b", k, i,
                   mem_addr[k], mem_write_data[k], mem_data_mask[k], e_addr[k], e_wd[k], e_mask[k]);
        end
        checks++;
        if ({a_rdata[k], b_rdata[k]} !== {e_ard[k], e_brd[k]}) begin
          errors++;
          $display("FAIL rand_rdata k=%0d i=%0d got %h %h exp %h %h", k, i,
                   a_rdata[k], b_rdata[k], e_ard[k], e_brd[k]);
        end
      end
      advance();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    cyc = 0;
    owner_b[0] = 0; owner_b[1] = 0;
    streak[0] = 0;  streak[1] = 0;
    rst = 1;
    idle_inputs();
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;
    a_mask = '0; b_mask = '0; mem_read_data = '0;

    test_reset();
    test_b_read();
    test_contention();
    test_write();
    test_interleaved();
    test_reset_mid_read();
    test_random(600);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Two-port arbiter sharing the single data-memory port (d_mem) between the core (port A) and a second master such as the SPI program loader or a debug/DMA engine (port B).
- Sits between the requesters and d_mem.
- Selects one request per cycle using bounded round-robin (burst cap) and muxes address, data, mask and enables to d_mem.
- Routes read data back to the owning requester with a matching valid strobe after the fixed memory read latency.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- READ_LATENCY, 1, cycles from mem_read_en to valid mem_read_data; legal range 1..4.
- MAX_BURST, 4, maximum consecutive grants to one port while the other port is requesting; legal range ≥1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- a_req  in  1  port A request; held until granted.
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  DATA_W  port A write data.
- a_mask  in  2  port A size: 00 byte, 01 half, 10 word.
- a_we  in  1  port A write.
- a_re  in  1  port A read.
- a_gnt  out  1  port A request accepted this cycle.
- a_rvalid  out  1  port A read data valid.
- a_rdata  out  DATA_W  port A read data.
- b_req, b_addr, b_wdata, b_mask, b_we, b_re, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- mem_addr  out  ADDR_W  to d_mem addr.
- mem_write_data  out  DATA_W  to d_mem write_data.
- mem_data_mask  out  2  to d_mem data_mask.
- mem_write_en  out  1  to d_mem write_en.
- mem_read_en  out  1  to d_mem read_en.
- mem_read_data  in  DATA_W  from d_mem read_data.

Behaviour:

*Reset*
- rst sampled on the clk rising edge.
- While rst is high: a_gnt = b_gnt = 0, mem_write_en = mem_read_en = 0, a_rvalid = b_rvalid = 0, read-return tag pipeline cleared.
- Reset state: last_owner = A, run_cnt = 0.

*Grant (combinational from req + state, one grant max per cycle)*
- Neither port requesting: no grant.
- Exactly one port requesting: grant that port.
- Both requesting: if run_cnt < MAX_BURST, grant last_owner; else grant the other port.

*State update (registered)*
- Grant to last_owner: run_cnt = min(run_cnt+1, MAX_BURST).
- Grant to the other port: last_owner = that port, run_cnt = 1.
- No grant: last_owner held, run_cnt = 0.

*Memory drive*
- In a grant cycle, the mem_* outputs mirror the granted port's addr, wdata, mask, we and re in the same cycle (zero-latency mux).
- mem_write_en = we & gnt.
- mem_read_en = re & ~we & gnt. If we and re are both high, the access is a write only, and no rvalid is ever produced for it.
- Non-grant cycles: mem_write_en = mem_read_en = 0; mem_addr, mem_write_data and mem_data_mask hold port A values (don't-care, but deterministic).

*Read return*
- Each read grant pushes a {valid, owner} tag into a READ_LATENCY-deep shift register.
- When the tag emerges, the owner's rvalid = 1 for exactly one cycle and its rdata = mem_read_data.
- The non-owner's rdata = 0. Both rdata outputs are 0 whenever their rvalid is 0.
- Back-to-back reads, including reads alternating between ports, return in order with no bubbles. One grant per cycle means returns cannot collide.

*Requester rules*
- A requester keeps req and its fields stable until it sees gnt.
- Dropping req before grant is permitted and cancels the request.
- A requester may issue a new request the cycle after gnt without waiting for its rvalid.

*Boundary conditions*
- rst asserted with reads in flight: the tags are discarded and no rvalid is produced after rst, even though d_mem may still return data.
- run_cnt saturates at MAX_BURST. It never wraps.
- With MAX_BURST = 1, contention yields strict alternation.
- A single port requesting alone is granted every cycle regardless of run_cnt (no starvation penalty).

Test Plan:
- Reset: hold rst 2 cycles with a_req = b_req = 1 -> all gnt/rvalid/mem enables 0. First cycle after release -> a_gnt = 1 (tie goes to A).
- B-only read: b_req = 1, b_re = 1, b_addr = 0x40 in cycle N; mem returns 0xDEADBEEF -> b_gnt at N, mem_read_en and mem_addr = 0x40 at N, b_rvalid = 1 and b_rdata = 0xDEADBEEF at N+1, a_rvalid = 0.
- Contention, MAX_BURST = 4, both ports requesting every cycle -> grant sequence A,A,A,A,B,B,B,B,A; repeat with MAX_BURST = 1 -> A,B,A,B.
- A write: a_we = 1, a_addr = 0x100, a_wdata = 0x12345678, a_mask = 10 -> same cycle mem_write_en = 1 with identical addr/data/mask; no rvalid on either port. Repeat with a_we = a_re = 1 -> write only, no rvalid.
- Interleaved reads, READ_LATENCY = 2: A reads at N, B reads at N+1 -> a_rvalid at N+2, b_rvalid at N+3, each carrying the mem_read_data of its own cycle.
- Reset mid-read: read granted at N, rst = 1 at N+1 -> no rvalid at N+1 or later; after release, the first contended grant goes to A.
